// File: rtl/freq_ctrl_pkg.sv
// rtl/freq_ctrl_pkg.sv - shared state type and decade divisors for the frequency gate controller
package freq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        LATCH,
        HOLD
    } fgc_state_t;

    localparam int DECADE_DIV [0:3] = '{1, 10, 100, 1000};

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - loadable down-counter that stops at zero; done flags the final counted cycle
module gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == W'(1));

endmodule

// File: rtl/freq_gate_controller.sv
// rtl/freq_gate_controller.sv - gate/clear/latch/hold sequencer for the frequency counter
// Optional decade auto-ranging is compiled in with AUTORANGE_EN.
module freq_gate_controller
    import freq_ctrl_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eden,
    input  logic       cnt_ovf,
    input  logic       cnt_under,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       disp_load,
    output logic       busy,
    output logic       ovf_flag,
    output logic [1:0] range
);

    localparam int TMAX = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    fgc_state_t    state_q, state_d;
    logic          sticky_q, sticky_d;
    logic          ovf_flag_q, ovf_flag_d;
    logic [1:0]    range_q, range_d;
    logic          gate_load, hold_load;
    logic          gate_done, hold_done;
    logic [TW-1:0] gate_len;
    logic          remeasure;

    always_comb begin
        case (range_q)
            2'd0:    gate_len = TW'(GATE_CYCLES);
            2'd1:    gate_len = TW'(GATE_CYCLES / DECADE_DIV[1]);
            2'd2:    gate_len = TW'(GATE_CYCLES / DECADE_DIV[2]);
            default: gate_len = TW'(GATE_CYCLES / DECADE_DIV[3]);
        endcase
    end

`ifdef AUTORANGE_EN
    // An overflowed window below the top range is retried one decade shorter instead of shown.
    assign remeasure = sticky_q && (range_q != 2'd3);
`else
    logic unused_under;
    assign unused_under = cnt_under;
    assign remeasure    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sticky_d   = sticky_q;
        ovf_flag_d = ovf_flag_q;
        range_d    = range_q;
        gate_load  = 1'b0;
        hold_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (eden) state_d = CLEAR;
            end
            CLEAR: begin
                gate_load = 1'b1;
                sticky_d  = 1'b0;
                state_d   = GATE;
            end
            GATE: begin
                if (cnt_ovf) sticky_d = 1'b1;
                if (!eden) begin
                    state_d = IDLE;
                end else if (gate_done) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                sticky_d = 1'b0;
                if (remeasure) begin
                    range_d = range_q + 2'd1;
                    state_d = CLEAR;
                end else begin
                    ovf_flag_d = sticky_q;
                    hold_load  = 1'b1;
                    state_d    = HOLD;
`ifdef AUTORANGE_EN
                    if (!sticky_q && cnt_under && range_q != 2'd0) range_d = range_q - 2'd1;
`endif
                end
            end
            HOLD: begin
                if (hold_done) state_d = eden ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sticky_q   <= 1'b0;
            ovf_flag_q <= 1'b0;
            range_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            sticky_q   <= sticky_d;
            ovf_flag_q <= ovf_flag_d;
            range_q    <= range_d;
        end
    end

    gate_timer #(.W(TW)) u_gate_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gate_load),
        .load_val (gate_len),
        .done     (gate_done)
    );

    gate_timer #(.W(TW)) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (TW'(HOLD_CYCLES)),
        .done     (hold_done)
    );

    assign cnt_clr   = (state_q == CLEAR);
    assign cnt_en    = (state_q == GATE);
    assign disp_load = (state_q == LATCH) && !remeasure;
    assign busy      = (state_q != IDLE);
    assign ovf_flag  = ovf_flag_q;
    assign range     = range_q;

endmodule

// File: tb/tb_freq_gate_controller.sv
// tb/tb_freq_gate_controller.sv - randomized bench against a window-offset model of the controller
module tb_freq_gate_controller;

    localparam int G = 1000;
    localparam int H = 200;
`ifdef AUTORANGE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eden = 1'b0;
    logic       cnt_ovf = 1'b0;
    logic       cnt_under = 1'b0;
    logic       cnt_clr, cnt_en, disp_load, busy, ovf_flag;
    logic [1:0] range;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_n   = 0;
    int en_cnt  = 0;
    int clr_q[$];
    int load_q[$];
    int en_snap_q[$];

    // Model: a window is described by its offset from the clear cycle.
    bit m_active = 0;
    int m_off    = 0;
    int m_glen   = G;
    bit m_sticky = 0;
    bit m_flag   = 0;
    int m_range  = 0;

    freq_gate_controller #(.GATE_CYCLES(G), .HOLD_CYCLES(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .eden      (eden),
        .cnt_ovf   (cnt_ovf),
        .cnt_under (cnt_under),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .disp_load (disp_load),
        .busy      (busy),
        .ovf_flag  (ovf_flag),
        .range     (range)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc_n, got, exp);
        end
    endtask

    function automatic bit m_remeasure();
        return AUTO && m_sticky && (m_range < 3);
    endfunction

    function automatic logic [6:0] model_outs();
        logic clr, en, ld, bsy;
        clr = 0; en = 0; ld = 0; bsy = 0;
        if (m_active) begin
            bsy = 1;
            clr = (m_off == 0);
            en  = (m_off >= 1) && (m_off <= m_glen);
            ld  = (m_off == m_glen + 1) && !m_remeasure();
        end
        return {clr, en, ld, bsy, m_flag, 2'(m_range)};
    endfunction

    task automatic model_step(input logic r, input logic e, input logic o, input logic u);
        if (r) begin
            m_active = 0; m_flag = 0; m_range = 0; m_sticky = 0;
        end else if (!m_active) begin
            if (e) begin
                m_active = 1; m_off = 0; m_glen = G / (10 ** m_range);
            end
        end else if (m_off == 0) begin
            m_sticky = 0; m_off = 1;
        end else if (m_off <= m_glen) begin
            if (o) m_sticky = 1;
            if (!e) m_active = 0;
            else m_off++;
        end else if (m_off == m_glen + 1) begin
            if (m_remeasure()) begin
                m_range++; m_off = 0; m_glen = G / (10 ** m_range);
            end else begin
                if (AUTO && !m_sticky && u && m_range > 0) m_range--;
                m_flag = m_sticky; m_off++;
            end
            m_sticky = 0;
        end else if (m_off == m_glen + 1 + H) begin
            if (e) begin
                m_off = 0; m_glen = G / (10 ** m_range);
            end else begin
                m_active = 0;
            end
        end else begin
            m_off++;
        end
    endtask

    task automatic run_cycle(input logic r, input logic e, input logic o, input logic u);
        rst = r; eden = e; cnt_ovf = o; cnt_under = u;
        model_step(r, e, o, u);
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (cnt_en) en_cnt++;
        if (cnt_clr) begin
            clr_q.push_back(cyc_n);
            en_snap_q.push_back(en_cnt);
        end
        if (disp_load) load_q.push_back(cyc_n);
        check_eq("outs", {cnt_clr, cnt_en, disp_load, busy, ovf_flag, range}, model_outs());
    endtask

    task automatic clear_log();
        clr_q.delete(); load_q.delete(); en_snap_q.delete(); en_cnt = 0;
    endtask

    initial begin
        int t;
        int ovf_div;

        repeat (3) run_cycle(1, 0, 0, 0);
        repeat (50) run_cycle(0, 0, 0, 0);
        check_eq("reset_outs", {cnt_clr, cnt_en, disp_load, busy, ovf_flag, range}, 7'd0);

        // Nominal cadence from the cycle eden rises.
        clear_log();
        t = cyc_n;
        repeat (1301) run_cycle(0, 1, 0, 0);
        check_eq("n_clr", clr_q.size(), 2);
        check_eq("n_load", load_q.size(), 1);
        if (clr_q.size() >= 2 && load_q.size() >= 1) begin
            check_eq("first_clr", clr_q[0], t + 1);
            check_eq("load_at", load_q[0], t + 1002);
            check_eq("next_clr", clr_q[1], t + 1203);
            check_eq("gate_len", en_snap_q[1] - en_snap_q[0], G);
        end

        // Abort 500 cycles into the gate.
        repeat (3) run_cycle(1, 0, 0, 0);
        clear_log();
        repeat (501) run_cycle(0, 1, 0, 0);
        run_cycle(0, 0, 0, 0);
        check_eq("abort_en", cnt_en, 0);
        check_eq("abort_busy", busy, 0);
        repeat (20) run_cycle(0, 0, 0, 0);
        check_eq("abort_noload", load_q.size(), 0);
        check_eq("abort_flag", ovf_flag, 0);

        repeat (3) run_cycle(1, 0, 0, 0);
        clear_log();
`ifdef AUTORANGE_EN
        repeat (1130) run_cycle(0, 1, 1, 0);
        check_eq("ar_range", range, 3);
        check_eq("ar_flag", ovf_flag, 1);
        check_eq("ar_loads", load_q.size(), 1);
        check_eq("ar_gate1", en_cnt, 1000 + 100 + 10 + 1);
`else
        for (int i = 0; i < 1210; i++) run_cycle(0, 1, (i == 300), 0);
        check_eq("ovf_flag_set", ovf_flag, 1);
        repeat (1202) run_cycle(0, 1, 0, 0);
        check_eq("ovf_flag_clr", ovf_flag, 0);
        check_eq("ovf_loads", load_q.size(), 2);
`endif
        run_cycle(1, 1, 0, 0);
        check_eq("rst_hold_range", range, 0);
        check_eq("rst_hold_busy", busy, 0);

        // Randomized segments with decreasing overflow density.
        for (int seg = 0; seg < 3; seg++) begin
            logic e;
            ovf_div = (seg == 0) ? 200 : (seg == 1) ? 3000 : 100000;
            e = 1'b1;
            for (int i = 0; i < 7000; i++) begin
                if ($urandom_range(699, 0) == 0) e = ~e;
                run_cycle(($urandom_range(2999, 0) == 0),
                          e,
                          ($urandom_range(ovf_div - 1, 0) == 0),
                          1'($urandom_range(1, 0)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
